// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational Alu between two
// requesters, with one operation in flight and a registered result handed back.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_a,
  input  logic             req_valid_b,
  output logic             req_ready_a,
  output logic             req_ready_b,
  input  logic [WIDTH-1:0] req_input1_a,
  input  logic [WIDTH-1:0] req_input1_b,
  input  logic [WIDTH-1:0] req_input2_a,
  input  logic [WIDTH-1:0] req_input2_b,
  input  logic [CTRW-1:0]  req_aluCtr_a,
  input  logic [CTRW-1:0]  req_aluCtr_b,
  output logic             rsp_valid_a,
  output logic             rsp_valid_b,
  input  logic             rsp_ready_a,
  input  logic             rsp_ready_b,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [CTRW-1:0]  alu_aluCtr,
  input  logic [WIDTH-1:0] alu_aluRes,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic [1:0]       state;
  logic             last;
  logic             owner;
  logic [WIDTH-1:0] issueIn1;
  logic [WIDTH-1:0] issueIn2;
  logic [CTRW-1:0]  issueCtr;
  logic             grantA;
  logic             grantB;
  logic             rspDone;

  // On a contest the requester that was not served last wins.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (req_valid_a && req_valid_b) begin
      grantA = (last == SEL_B);
      grantB = (last == SEL_A);
    end else begin
      grantA = req_valid_a;
      grantB = req_valid_b;
    end
  end

  assign req_ready_a = (state == IDLE) && grantA;
  assign req_ready_b = (state == IDLE) && grantB;
  assign rsp_valid_a = (state == RESP) && (owner == SEL_A);
  assign rsp_valid_b = (state == RESP) && (owner == SEL_B);
  assign rspDone     = (state == RESP) && ((owner == SEL_A) ? rsp_ready_a : rsp_ready_b);
  assign busy        = (state != IDLE);

  assign alu_input1 = issueIn1;
  assign alu_input2 = issueIn2;
  assign alu_aluCtr = issueCtr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= SEL_B;
      owner    <= SEL_A;
      issueIn1 <= '0;
      issueIn2 <= '0;
      issueCtr <= '0;
      rsp_res  <= '0;
      rsp_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready_a) begin
            issueIn1 <= req_input1_a;
            issueIn2 <= req_input2_a;
            issueCtr <= req_aluCtr_a;
            owner    <= SEL_A;
            state    <= EXEC;
          end else if (req_ready_b) begin
            issueIn1 <= req_input1_b;
            issueIn2 <= req_input2_b;
            issueCtr <= req_aluCtr_b;
            owner    <= SEL_B;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_res  <= alu_aluRes;
          rsp_zero <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (rspDone) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter; a behavioural Alu drives the
// datapath and expected grants/results come from the round-robin rules.
module tb_alu_arbiter;

  localparam bit PORT_A = 1'b0;
  localparam bit PORT_B = 1'b1;

  logic        clk;
  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b;
  logic [31:0] req_input1_a, req_input1_b;
  logic [31:0] req_input2_a, req_input2_b;
  logic [3:0]  req_aluCtr_a, req_aluCtr_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic        rsp_ready_a, rsp_ready_b;
  logic [31:0] rsp_res;
  logic        rsp_zero;
  logic [31:0] alu_input1, alu_input2;
  logic [3:0]  alu_aluCtr;
  logic [31:0] alu_aluRes;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit lastModel;

  alu_arbiter #(.WIDTH(32), .CTRW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
    .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
    .req_input1_a(req_input1_a), .req_input1_b(req_input1_b),
    .req_input2_a(req_input2_a), .req_input2_b(req_input2_b),
    .req_aluCtr_a(req_aluCtr_a), .req_aluCtr_b(req_aluCtr_b),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
    .rsp_ready_a(rsp_ready_a), .rsp_ready_b(rsp_ready_b),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_aluCtr(alu_aluCtr),
    .alu_aluRes(alu_aluRes), .alu_zero(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'b0000: aluRef = a & b;
      4'b0001: aluRef = a | b;
      4'b0010: aluRef = a + b;
      4'b0110: aluRef = a - b;
      4'b0111: aluRef = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: aluRef = ~(a | b);
      default: aluRef = 32'd0;
    endcase
  endfunction

  assign alu_aluRes = aluRef(alu_input1, alu_input2, alu_aluCtr);
  assign alu_zero   = (alu_aluRes == 32'd0);

  function automatic bit expectedGrant(input logic va, input logic vb, input bit lastServed);
    if (va && !vb)      expectedGrant = PORT_A;
    else if (vb && !va) expectedGrant = PORT_B;
    else                expectedGrant = ~lastServed;
  endfunction

  function automatic logic [3:0] randomCtr();
    logic [3:0] ctrs [6];
    ctrs = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    randomCtr = ctrs[$urandom_range(0, 5)];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] c);
    if (port == PORT_A) begin
      req_input1_a = a; req_input2_a = b; req_aluCtr_a = c; req_valid_a = 1'b1;
    end else begin
      req_input1_b = a; req_input2_b = b; req_aluCtr_b = c; req_valid_b = 1'b1;
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_valid", {rsp_valid_a, rsp_valid_b}, 2'b00);
    checkOutput("reset_alu", {alu_input1, alu_input2, alu_aluCtr}, 0);
    checkOutput("reset_rsp", {rsp_res, rsp_zero}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    lastModel = PORT_B;
  endtask

  // Called at a negedge in IDLE with requests already driven; returns at a negedge in IDLE.
  task automatic serveOne(input bit expPort, input int hold, input bit raiseOther);
    int          waitCycles;
    logic [31:0] e1, e2, eRes;
    logic [3:0]  ec;
    waitCycles = 0;
    #1;
    while (!(req_ready_a || req_ready_b) && waitCycles < 8) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("accept_wait", waitCycles, 0);
    checkOutput("grant", {req_ready_a, req_ready_b}, (expPort == PORT_B) ? 2'b01 : 2'b10);
    e1 = (expPort == PORT_B) ? req_input1_b : req_input1_a;
    e2 = (expPort == PORT_B) ? req_input2_b : req_input2_a;
    ec = (expPort == PORT_B) ? req_aluCtr_b : req_aluCtr_a;
    eRes = aluRef(e1, e2, ec);
    @(posedge clk);
    @(negedge clk);
    checkOutput("exec_busy", busy, 1);
    checkOutput("exec_rsp_valid", {rsp_valid_a, rsp_valid_b}, 2'b00);
    checkOutput("exec_req_ready", {req_ready_a, req_ready_b}, 2'b00);
    checkOutput("exec_alu", {alu_input1, alu_input2, alu_aluCtr}, {e1, e2, ec});
    if (expPort == PORT_B) begin
      req_valid_b = 1'b0;
      if (raiseOther) req_valid_a = 1'b1;
      rsp_ready_b = (hold == 0);
      rsp_ready_a = 1'b1;
    end else begin
      req_valid_a = 1'b0;
      if (raiseOther) req_valid_b = 1'b1;
      rsp_ready_a = (hold == 0);
      rsp_ready_b = 1'b1;
    end
    @(negedge clk);
    checkOutput("resp_valid", {rsp_valid_a, rsp_valid_b}, (expPort == PORT_B) ? 2'b01 : 2'b10);
    checkOutput("resp_res", rsp_res, eRes);
    checkOutput("resp_zero", rsp_zero, (eRes == 32'd0));
    checkOutput("resp_req_ready", {req_ready_a, req_ready_b}, 2'b00);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {rsp_valid_a, rsp_valid_b}, (expPort == PORT_B) ? 2'b01 : 2'b10);
      checkOutput("hold_res", {rsp_res, rsp_zero}, {eRes, (eRes == 32'd0)});
      checkOutput("hold_req_ready", {req_ready_a, req_ready_b}, 2'b00);
      checkOutput("hold_busy", busy, 1);
    end
    if (expPort == PORT_B) rsp_ready_b = 1'b1;
    else                   rsp_ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_rsp_valid", {rsp_valid_a, rsp_valid_b}, 2'b00);
    lastModel = expPort;
  endtask

  initial begin
    reset = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_input1_a = '0; req_input2_a = '0; req_aluCtr_a = '0;
    req_input1_b = '0; req_input2_b = '0; req_aluCtr_b = '0;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    lastModel = PORT_B;

    resetDut();

    // A alone: 5 + 7
    @(negedge clk);
    applyStimulus(PORT_A, 32'd5, 32'd7, 4'b0010);
    serveOne(PORT_A, 0, 0);

    // Both valid from reset: A first, then strict alternation
    resetDut();
    applyStimulus(PORT_A, 32'd3, 32'd4, 4'b0010);
    applyStimulus(PORT_B, 32'd9, 32'd9, 4'b0110);
    serveOne(expectedGrant(req_valid_a, req_valid_b, lastModel), 0, 0);
    checkOutput("first_winner", lastModel, PORT_A);
    applyStimulus(PORT_A, $urandom, $urandom, randomCtr());
    serveOne(PORT_B, 0, 0);
    applyStimulus(PORT_B, $urandom, $urandom, randomCtr());
    serveOne(PORT_A, 0, 0);
    serveOne(PORT_B, 0, 0);

    // Backpressure on B, A raised meanwhile and accepted right after
    applyStimulus(PORT_B, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'b0000);
    req_input1_a = 32'd100; req_input2_a = 32'd1; req_aluCtr_a = 4'b0110;
    serveOne(PORT_B, 5, 1);
    serveOne(PORT_A, 0, 0);

    // Non-owner ready ignored while A response is held back
    applyStimulus(PORT_A, 32'd20, 32'd22, 4'b0001);
    serveOne(PORT_A, 3, 0);

    // Reset during EXEC
    applyStimulus(PORT_A, 32'd11, 32'd13, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midop_exec_busy", busy, 1);
    reset = 1'b0;
    req_valid_a = 1'b0;
    #1;
    checkOutput("midop_exec_busy_rst", busy, 0);
    checkOutput("midop_exec_rsp_valid", {rsp_valid_a, rsp_valid_b}, 2'b00);
    checkOutput("midop_exec_alu", {alu_input1, alu_input2, alu_aluCtr}, 0);
    @(negedge clk);
    reset = 1'b1;
    lastModel = PORT_B;

    // Reset during RESP
    applyStimulus(PORT_A, 32'd40, 32'd2, 4'b0010);
    rsp_ready_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    checkOutput("midop_resp_valid", {rsp_valid_a, rsp_valid_b}, 2'b10);
    reset = 1'b0;
    #1;
    checkOutput("midop_resp_valid_rst", {rsp_valid_a, rsp_valid_b}, 2'b00);
    checkOutput("midop_resp_res_rst", {rsp_res, rsp_zero}, 0);
    checkOutput("midop_resp_alu_rst", {alu_input1, alu_input2, alu_aluCtr}, 0);
    @(negedge clk);
    reset = 1'b1;
    lastModel = PORT_B;
    rsp_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", {busy, rsp_valid_a, rsp_valid_b}, 3'b000);
    end
    applyStimulus(PORT_A, 32'd6, 32'd6, 4'b0110);
    applyStimulus(PORT_B, 32'd1, 32'd2, 4'b0010);
    serveOne(PORT_A, 0, 0);
    serveOne(PORT_B, 0, 0);

    // B streaming alone
    for (int i = 0; i < 4; i++) begin
      applyStimulus(PORT_B, $urandom, $urandom, randomCtr());
      serveOne(PORT_B, 0, 0);
    end

    // Randomized traffic; an unserved request keeps its operands until accepted
    for (int i = 0; i < 24; i++) begin
      if (!req_valid_a && ($urandom_range(0, 1) == 1))
        applyStimulus(PORT_A, $urandom, $urandom_range(0, 3), randomCtr());
      if (!req_valid_b && ($urandom_range(0, 1) == 1))
        applyStimulus(PORT_B, $urandom, $urandom, randomCtr());
      if (!req_valid_a && !req_valid_b)
        applyStimulus(bit'($urandom_range(0, 1)), $urandom, $urandom, randomCtr());
      serveOne(expectedGrant(req_valid_a, req_valid_b, lastModel), $urandom_range(0, 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
